// File: rtl/brg_param_if.sv
// Bus interface for brg_param.
// Purpose: groups the run-control, divisor-load and strobe signals of the
// SPART baud-rate generator so that the design and its driver share one bundle.
// Signals:
//   en         run enable (master -> slave)
//   load_high  write shadow high divisor from data_in (master -> slave)
//   load_low   write shadow low divisor from data_in and arm a commit (master -> slave)
//   load_frac  write shadow fraction from data_in (master -> slave)
//   data_in    8-bit load data (master -> slave)
//   rx_resync  restart receive phase at half an rx period (master -> slave)
//   brg_ready  a divisor has been committed since reset (slave -> master)
//   tx_enable  one-cycle transmit bit-rate strobe (slave -> master)
//   rx_enable  one-cycle receive oversample strobe (slave -> master)
interface brg_param_if;
    logic       en;
    logic       load_high;
    logic       load_low;
    logic       load_frac;
    logic [7:0] data_in;
    logic       rx_resync;
    logic       brg_ready;
    logic       tx_enable;
    logic       rx_enable;

    modport master (
        output en, load_high, load_low, load_frac, data_in, rx_resync,
        input  brg_ready, tx_enable, rx_enable
    );

    modport slave (
        input  en, load_high, load_low, load_frac, data_in, rx_resync,
        output brg_ready, tx_enable, rx_enable
    );
endinterface

// File: rtl/brg_param.sv
// brg_param: parametrised baud-rate generator for the SPART datapath.
// Purpose: produces one-cycle tx_enable (bit rate) and rx_enable (oversample
// rate) strobes from a divisor D loaded byte-wise through shadow registers.
// A loaded divisor is committed when idle, or at a tx tick boundary when
// running, so no strobe period ever mixes old and new divisors.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  brg_param_if.slave (en, load_high, load_low, load_frac, data_in,
//        rx_resync in; brg_ready, tx_enable, rx_enable out)
// Parameters: DIV_W divisor width (>= 9), OS_LOG2 log2 rx oversampling ratio,
//   FRAC_W fractional divisor width.
// Build option: define BRG_FRAC_EN to implement the fractional divisor
//   (load_frac, shadow fraction, active fraction and accumulator). Without it
//   load_frac is ignored and the tx period is exactly D+1.
module brg_param #(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned OS_LOG2 = 4,
    parameter int unsigned FRAC_W  = 4
) (
    input  logic       clk,
    input  logic       rst,
    brg_param_if.slave bus
);

    localparam int unsigned HI_W  = DIV_W - 8;
    localparam int unsigned CNT_W = DIV_W + 1;
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(16'h028B);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [HI_W-1:0]   sh_q, sh_d;
    logic [7:0]        sl_q, sl_d;
    logic              pending_q, pending_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  cnt_tx_q, cnt_tx_d;
    logic [DIV_W-1:0]  cnt_rx_q, cnt_rx_d;

    logic              ready_c;
    logic              tx_tick_c;
    logic              rx_zero_c;
    logic              rx_tick_c;
    logic              commit_c;
    logic              carry_c;
    logic [DIV_W-1:0]  shadow_c;
    logic [DIV_W-1:0]  rate_rx_c;
    logic [DIV_W-1:0]  shadow_rx_c;

    assign shadow_c    = {sh_q, sl_q};
    assign rate_rx_c   = div_q >> OS_LOG2;
    assign shadow_rx_c = shadow_c >> OS_LOG2;

    // State register: IDLE until the first commit, RUN afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pending_q) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / strobe decode: strobes depend on registered counters, gated by en.
    always_comb begin
        ready_c   = 1'b0;
        tx_tick_c = 1'b0;
        rx_zero_c = 1'b0;
        rx_tick_c = 1'b0;
        commit_c  = 1'b0;
        case (state_q)
            S_IDLE: commit_c = pending_q;
            S_RUN: begin
                ready_c   = 1'b1;
                tx_tick_c = bus.en && (cnt_tx_q == '0);
                rx_zero_c = bus.en && (cnt_rx_q == '0);
                // A resync cycle never emits an rx strobe.
                rx_tick_c = rx_zero_c && !bus.rx_resync;
                // Running: commit only at a tx period boundary.
                commit_c  = pending_q && tx_tick_c;
            end
            default: ;
        endcase
    end

    assign bus.brg_ready = ready_c;
    assign bus.tx_enable = tx_tick_c;
    assign bus.rx_enable = rx_tick_c;

    // Shadow loads, commit and counter next-state.
    always_comb begin
        sh_d      = sh_q;
        sl_d      = sl_q;
        pending_d = pending_q;
        div_d     = div_q;
        cnt_tx_d  = cnt_tx_q;
        cnt_rx_d  = cnt_rx_q;

        // Commit consumes the shadow as it stood before this edge; a load on
        // the same edge re-arms pending for the following boundary.
        if (commit_c) pending_d = 1'b0;
        if (bus.load_high) begin
            sh_d = HI_W'(bus.data_in);
        end else if (bus.load_low) begin
            sl_d      = bus.data_in;
            pending_d = 1'b1;
        end

        if (commit_c) begin
            div_d    = shadow_c;
            cnt_tx_d = {1'b0, shadow_c};
            cnt_rx_d = shadow_rx_c;
        end else if (ready_c && bus.en) begin
            if (tx_tick_c) cnt_tx_d = {1'b0, div_q} + CNT_W'(carry_c);
            else           cnt_tx_d = cnt_tx_q - CNT_W'(1);
            if (rx_zero_c) cnt_rx_d = rate_rx_c;
            else           cnt_rx_d = cnt_rx_q - DIV_W'(1);
        end

        // Start-bit resync restarts rx at mid-period, overriding any reload.
        if (ready_c && bus.en && bus.rx_resync) begin
            cnt_rx_d = (commit_c ? shadow_rx_c : rate_rx_c) >> 1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q      <= DIV_RST[DIV_W-1:8];
            sl_q      <= DIV_RST[7:0];
            pending_q <= 1'b0;
            div_q     <= DIV_RST;
            cnt_tx_q  <= '0;
            cnt_rx_q  <= '0;
        end else begin
            sh_q      <= sh_d;
            sl_q      <= sl_d;
            pending_q <= pending_d;
            div_q     <= div_d;
            cnt_tx_q  <= cnt_tx_d;
            cnt_rx_q  <= cnt_rx_d;
        end
    end

`ifdef BRG_FRAC_EN
    logic [FRAC_W-1:0] sf_q, sf_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0]   frac_sum_c;

    // Fraction accumulator: its carry stretches one tx period by a cycle.
    always_comb begin
        sf_d       = sf_q;
        frac_d     = frac_q;
        acc_d      = acc_q;
        carry_c    = 1'b0;
        frac_sum_c = {1'b0, acc_q} + {1'b0, frac_q};
        if (bus.load_frac) sf_d = FRAC_W'(bus.data_in);
        if (commit_c) begin
            frac_d = sf_q;
            acc_d  = '0;
        end else if (tx_tick_c) begin
            acc_d   = frac_sum_c[FRAC_W-1:0];
            carry_c = frac_sum_c[FRAC_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sf_q   <= '0;
            frac_q <= '0;
            acc_q  <= '0;
        end else begin
            sf_q   <= sf_d;
            frac_q <= frac_d;
            acc_q  <= acc_d;
        end
    end
`else
    logic unused_frac;
    assign carry_c     = 1'b0;
    assign unused_frac = bus.load_frac ^ (FRAC_W == 0);
`endif

endmodule

// File: doc/brg_param.md
# brg_param

Parametrised baud-rate generator for the SPART datapath, generating one-cycle `tx_enable` and `rx_enable` strobes for the transmitter and the oversampling receiver. It generalises divisor width and oversampling ratio, and adds:
- an optional fractional divisor;
- shadowed divisor registers with glitch-free commit at a tick boundary;
- receiver phase resynchronisation on start-bit detection.

## Interface
- `DIV_W`, 16, integer divisor width in bits (≥ 9; loaded as high byte `DIV_W-8` bits + low byte 8 bits).
- `OS_LOG2`, 4, log2 of the receive oversampling ratio (rx divisor = D >> OS_LOG2).
- `FRAC_W`, 4, fractional divisor width (used only with `BRG_FRAC_EN`).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  run enable; low freezes counters/accumulator and forces both strobes low.
- `load_high`  in  1  write `data_in[DIV_W-9:0]` to shadow high divisor.
- `load_low`  in  1  write `data_in` to shadow low divisor and arm commit (pending).
- `load_frac`  in  1  write `data_in[FRAC_W-1:0]` to shadow fraction (no commit armed).
- `data_in`  in  8  load data.
- `rx_resync`  in  1  restart receive phase at half an rx period (start-bit edge).
- `brg_ready`  out  1  high once a divisor has been committed since reset.
- `tx_enable`  out  1  one-cycle transmit bit-rate strobe.
- `rx_enable`  out  1  one-cycle receive oversample strobe.

## Operation
- Registers: shadow {SH, SL, SF}; active D (DIV_W), F (FRAC_W), R = D >> OS_LOG2; `pending`; `ready`; `cnt_tx` (DIV_W+1 bits); `cnt_rx` (DIV_W bits); `acc` (FRAC_W).
- Reset values: SH:SL = 0x028B, SF = 0; D = 0x028B, F = 0; `pending` = 0, `ready` = 0; counters and `acc` = 0. All outputs are 0 during and after reset until ready.
- Load priority: `load_high` over `load_low` when both are asserted in the same cycle (the low write is dropped). `load_frac` is independent.
- `load_low` sets `pending`; a later load before commit overwrites the shadow and keeps `pending`.
- Commit of D←{SH,SL}, F←SF, acc←0, pending←0:
  - IDLE (`ready` = 0): on the edge after `pending` is seen. Also sets `ready` = 1, `cnt_tx` = D_new, `cnt_rx` = R_new.
  - RUN (`ready` = 1): only on a tx-tick edge. `cnt_tx` and `cnt_rx` reload from the new values, so no period ever mixes old and new divisors.
- A `load_low` coinciding with a tick edge is not yet in the shadow; it commits at the following tick.
- `tx_enable` = ready & en & (cnt_tx == 0).
  - On a tick: {c, acc} ← acc + F; cnt_tx ← D + c.
  - Otherwise: cnt_tx decrements.
  - Tx period = D+1 cycles, or D+2 when the carry is set.
- `rx_enable` = ready & en & (cnt_rx == 0).
  - On a tick: cnt_rx ← R.
  - Otherwise: cnt_rx decrements.
  - Rx period = R+1; no fraction applies.
- `rx_resync` (ready & en): cnt_rx ← R >> 1 and `rx_enable` is suppressed that cycle. It has priority over tick reload; tx is unaffected.
- Boundaries:
  - D = 0 → tx_enable every cycle (every other cycle on carry).
  - R = 0 → rx_enable every cycle.
  - cnt_tx's extra bit prevents overflow at D = all-ones with carry.
- `rst` mid-operation: immediate return to reset values; shadow writes in flight are lost.

## Timing
- Strobes are combinational decodes of registered counters only (no input-to-output paths).
- First strobe: commit at edge k → first tx_enable in cycle k+D, first rx_enable in cycle k+R.
- `brg_ready` rises one edge after the arming `load_low` while idle.
- `en` low: state holds exactly and strobes are 0. On re-enable, counting resumes from the held values.

## Configuration
- `BRG_FRAC_EN` defined:
  - `load_frac`, SF, F and `acc` are implemented.
  - Tx period alternates between D+1 and D+2 to average D+1+F/2^FRAC_W.
- Undefined:
  - `load_frac` is ignored and no fraction logic exists (c ≡ 0).
  - Tx period is exactly D+1.
  - All other behaviour is identical.

## Test plan
- Reset, then `load_high` 0x02 and `load_low` 0x8B → brg_ready rises next edge. tx_enable every 652 cycles; rx_enable every 41 cycles (R = 40).
- With `BRG_FRAC_EN`, FRAC_W = 4, `load_frac` 0x08 then commit D = 0x028B → tx periods alternate 652, 653. With the macro undefined → constant 652.
- While running at D = 0x028B, load D = 0x0010 mid-period → the current 652-cycle period completes unchanged, then tx period is 17 and rx period is 2.
- `rx_resync` pulse with R = 40 → rx_enable low for that cycle, next rx_enable exactly 20 cycles later; tx_enable spacing undisturbed.
- `load_high` and `load_low` asserted together with data 0x05 → high byte 0x05, low byte unchanged, `pending` not set, no commit.
- Assert `rst` mid-period, then `en` low for 10 cycles → outputs 0 immediately and ready = 0 after reset. With `en` low, strobes stay 0 and counters hold; the next tick is delayed by exactly 10 cycles.
